// File: rtl/kl11_console.sv
// kl11_console: KL11/DL11 console UART with RCSR/RBUF/XCSR/XBUF registers.
// Define KL11_LOOPBACK_EN to make XCSR MAINT writable (internal tx->rx loop).
module kl11_console #(
  parameter int CLK_DIV = 434
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [12:0] iopage_addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        decode,
  input  logic        iopage_rd,
  input  logic        iopage_wr,
  input  logic        iopage_byte_op,
  input  logic        rx,
  output logic        tx,
  output logic        rx_int,
  output logic        tx_int
);

  localparam logic [12:0] BASE    = 13'o17560;
  localparam logic [11:0] DIV_M1  = 12'(CLK_DIV - 1);
  localparam logic [11:0] HALF_M1 = 12'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;

  logic [1:0]  sel;
  logic        lo_acc;
  logic        wr_lo;
  logic        rd_rbuf;
  logic        xbuf_ld;
  logic        rie;
  logic        tie;
  logic        maint;
  logic        done;
  logic        ovr;
  logic        fe;
  logic [7:0]  rdata;
  logic        ready;
  logic        tx_q;
  logic [1:0]  sync;
  logic        rx_prev;
  logic        rx_in;
  logic [15:0] word;
  logic        unused_bits;

  assign unused_bits = ^data_in;

  assign decode  = iopage_addr[12:3] == BASE[12:3];
  assign sel     = iopage_addr[2:1];
  // Odd-address byte writes only reach bits 15:8, none writable here
  assign lo_acc  = !(iopage_byte_op && iopage_addr[0]);
  assign wr_lo   = iopage_wr && decode && lo_acc;
  assign rd_rbuf = iopage_rd && decode && lo_acc && sel == 2'd1;
  assign xbuf_ld = wr_lo && sel == 2'd3 && ready;

`ifdef KL11_LOOPBACK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      maint <= 1'b0;
    end else if (wr_lo && sel == 2'd2) begin
      maint <= data_in[2];
    end
  end
`else
  assign maint = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rie <= 1'b0;
      tie <= 1'b0;
    end else if (wr_lo) begin
      if (sel == 2'd0) rie <= data_in[6];
      if (sel == 2'd2) tie <= data_in[6];
    end
  end

  // Loopback taps the raw tx stream, bypassing the synchronizer
  assign rx_in = maint ? tx_q : sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], rx};
      rx_prev <= rx_in;
    end
  end

  st_t        rs_q, rs_d;
  logic [11:0] rcnt_q, rcnt_d;
  logic [3:0]  rbit_q, rbit_d;
  logic [7:0]  rsh_q, rsh_d;
  logic        rx_done;
  logic        rx_fe;

  always_comb begin
    rs_d    = rs_q;
    rcnt_d  = rcnt_q;
    rbit_d  = rbit_q;
    rsh_d   = rsh_q;
    rx_done = 1'b0;
    rx_fe   = 1'b0;
    unique case (rs_q)
      IDLE: begin
        if (rx_prev && !rx_in) begin
          rs_d   = START;
          rcnt_d = HALF_M1;
        end
      end
      START: begin
        if (rcnt_q == 12'd0) begin
          if (rx_in) begin
            rs_d = IDLE;
          end else begin
            rs_d   = DATA;
            rcnt_d = DIV_M1;
            rbit_d = 4'd0;
          end
        end else begin
          rcnt_d = rcnt_q - 12'd1;
        end
      end
      DATA: begin
        if (rcnt_q == 12'd0) begin
          rsh_d  = {rx_in, rsh_q[7:1]};
          rcnt_d = DIV_M1;
          rbit_d = rbit_q + 4'd1;
          if (rbit_q == 4'd7) rs_d = STOP;
        end else begin
          rcnt_d = rcnt_q - 12'd1;
        end
      end
      STOP: begin
        if (rcnt_q == 12'd0) begin
          rx_done = 1'b1;
          rx_fe   = !rx_in;
          rs_d    = IDLE;
        end else begin
          rcnt_d = rcnt_q - 12'd1;
        end
      end
      default: rs_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs_q   <= IDLE;
      rcnt_q <= 12'd0;
      rbit_q <= 4'd0;
      rsh_q  <= 8'd0;
    end else begin
      rs_q   <= rs_d;
      rcnt_q <= rcnt_d;
      rbit_q <= rbit_d;
      rsh_q  <= rsh_d;
    end
  end

  // A completion on the same edge as an RBUF read wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done  <= 1'b0;
      ovr   <= 1'b0;
      fe    <= 1'b0;
      rdata <= 8'd0;
    end else if (rx_done) begin
      done  <= 1'b1;
      ovr   <= done;
      fe    <= rx_fe;
      rdata <= rsh_q;
    end else if (rd_rbuf) begin
      done <= 1'b0;
      ovr  <= 1'b0;
      fe   <= 1'b0;
    end
  end

  st_t        ts_q, ts_d;
  logic [11:0] tcnt_q, tcnt_d;
  logic [3:0]  tbit_q, tbit_d;
  logic [7:0]  tsh_q, tsh_d;
  logic        tx_d;
  logic        tx_fin;

  always_comb begin
    ts_d   = ts_q;
    tcnt_d = tcnt_q;
    tbit_d = tbit_q;
    tsh_d  = tsh_q;
    tx_d   = tx_q;
    tx_fin = 1'b0;
    unique case (ts_q)
      IDLE: begin
        if (xbuf_ld) begin
          ts_d   = START;
          tcnt_d = 12'd0;
          tsh_d  = data_in[7:0];
        end
      end
      START: begin
        if (tcnt_q == 12'd0) begin
          tx_d   = 1'b0;
          tcnt_d = DIV_M1;
          tbit_d = 4'd0;
          ts_d   = DATA;
        end else begin
          tcnt_d = tcnt_q - 12'd1;
        end
      end
      DATA: begin
        if (tcnt_q == 12'd0) begin
          tx_d   = tsh_q[0];
          tsh_d  = {1'b0, tsh_q[7:1]};
          tcnt_d = DIV_M1;
          tbit_d = tbit_q + 4'd1;
          if (tbit_q == 4'd7) ts_d = STOP;
        end else begin
          tcnt_d = tcnt_q - 12'd1;
        end
      end
      STOP: begin
        if (tcnt_q == 12'd0) begin
          if (tbit_q == 4'd8) begin
            tx_d   = 1'b1;
            tbit_d = 4'd9;
            tcnt_d = DIV_M1;
          end else begin
            tx_fin = 1'b1;
            ts_d   = IDLE;
          end
        end else begin
          tcnt_d = tcnt_q - 12'd1;
        end
      end
      default: ts_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q   <= IDLE;
      tcnt_q <= 12'd0;
      tbit_q <= 4'd0;
      tsh_q  <= 8'd0;
      tx_q   <= 1'b1;
      ready  <= 1'b1;
    end else begin
      ts_q   <= ts_d;
      tcnt_q <= tcnt_d;
      tbit_q <= tbit_d;
      tsh_q  <= tsh_d;
      tx_q   <= tx_d;
      if (xbuf_ld) ready <= 1'b0;
      else if (tx_fin) ready <= 1'b1;
    end
  end

  assign tx     = maint ? 1'b1 : tx_q;
  assign rx_int = rie & done;
  assign tx_int = tie & ready;

  always_comb begin
    word     = 16'd0;
    data_out = 16'd0;
    unique case (1'b1)
      sel == 2'd0: word = {8'd0, done, rie, 6'd0};
      sel == 2'd1: word = {fe | ovr, ovr, fe, 5'd0, rdata};
      sel == 2'd2: word = {8'd0, ready, tie, 3'd0, maint, 2'd0};
      default:     word = 16'd0;
    endcase
    if (iopage_rd && decode) begin
      if (!iopage_byte_op) data_out = word;
      else if (iopage_addr[0]) data_out = {8'd0, word[15:8]};
      else data_out = {8'd0, word[7:0]};
    end
  end

endmodule

// File: tb/tb_kl11_console.sv
// tb_kl11_console: randomized self-checking bench for kl11_console.
// Reference model tracks RBUF/RCSR from frame-level events.
module tb_kl11_console;
  localparam int D = 8;
  localparam logic [12:0] A_RCSR = 13'o17560;
  localparam logic [12:0] A_RBUF = 13'o17562;
  localparam logic [12:0] A_XCSR = 13'o17564;
  localparam logic [12:0] A_XBUF = 13'o17566;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] iopage_addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        decode;
  logic        iopage_rd = 1'b0;
  logic        iopage_wr = 1'b0;
  logic        iopage_byte_op = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
  logic        rx_int;
  logic        tx_int;

  int checks = 0;
  int errors = 0;

  bit       m_done, m_ovr, m_fe, m_rie;
  logic [7:0] m_data;

  kl11_console #(.CLK_DIV(D)) dut (
    .clk(clk), .reset_n(reset_n),
    .iopage_addr(iopage_addr), .data_in(data_in),
    .data_out(data_out), .decode(decode),
    .iopage_rd(iopage_rd), .iopage_wr(iopage_wr),
    .iopage_byte_op(iopage_byte_op),
    .rx(rx), .tx(tx), .rx_int(rx_int), .tx_int(tx_int)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] exp_rbuf();
    logic [15:0] v;
    v = {8'h00, m_data};
    if (m_ovr) v |= 16'o140000;
    if (m_fe) v |= 16'o120000;
    return v;
  endfunction

  function automatic logic [15:0] exp_rcsr();
    logic [15:0] v;
    v = 16'd0;
    if (m_done) v |= 16'o200;
    if (m_rie) v |= 16'o100;
    return v;
  endfunction

  task automatic model_reset();
    m_done = 0; m_ovr = 0; m_fe = 0; m_rie = 0; m_data = 8'h00;
  endtask

  task automatic model_rx(input logic [7:0] b, input bit stop);
    m_ovr = m_done;
    m_fe = !stop;
    m_data = b;
    m_done = 1;
  endtask

  task automatic model_rd();
    m_done = 0; m_ovr = 0; m_fe = 0;
  endtask

  task automatic bus_write(input logic [12:0] a, input logic [15:0] d,
                           input bit bop);
    @(negedge clk);
    iopage_addr = a; data_in = d; iopage_byte_op = bop; iopage_wr = 1'b1;
    @(posedge clk); #1;
    iopage_wr = 1'b0; iopage_byte_op = 1'b0;
  endtask

  task automatic bus_read(input logic [12:0] a, input bit bop,
                          output logic [15:0] d);
    @(negedge clk);
    iopage_addr = a; iopage_byte_op = bop; iopage_rd = 1'b1;
    #1 d = data_out;
    @(posedge clk); #1;
    iopage_rd = 1'b0; iopage_byte_op = 1'b0;
  endtask

  task automatic peek(input logic [12:0] a, output logic [15:0] d);
    iopage_addr = a; iopage_rd = 1'b1;
    #1 d = data_out;
    iopage_rd = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    @(negedge clk); rx = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (D) @(negedge clk);
    end
    rx = stop;
    repeat (D) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    @(negedge clk); reset_n = 1'b1;
    model_reset();
    bus_read(A_RCSR, 0, d);
    checks++; if (d !== 16'o000000) begin errors++; $display("FAIL reset_rcsr got %o want 000000", d); end
    bus_read(A_RBUF, 0, d);
    checks++; if (d !== 16'o000000) begin errors++; $display("FAIL reset_rbuf got %o want 000000", d); end
    bus_read(A_XCSR, 0, d);
    checks++; if (d !== 16'o000200) begin errors++; $display("FAIL reset_xcsr got %o want 000200", d); end
    bus_read(A_XBUF, 0, d);
    checks++; if (d !== 16'o000000) begin errors++; $display("FAIL reset_xbuf got %o want 000000", d); end
    checks++; if ({rx_int, tx_int} !== 2'b00) begin errors++; $display("FAIL reset_int got %b want 00", {rx_int, tx_int}); end
    iopage_addr = 13'o17567; #1;
    checks++; if (decode !== 1'b1) begin errors++; $display("FAIL decode_hi got %b want 1", decode); end
    iopage_addr = 13'o17570; #1;
    checks++; if (decode !== 1'b0) begin errors++; $display("FAIL decode_above got %b want 0", decode); end
    iopage_addr = 13'o17557; #1;
    checks++; if (decode !== 1'b0) begin errors++; $display("FAIL decode_below got %b want 0", decode); end
    peek(13'o17574, d);
    checks++; if (d !== 16'd0) begin errors++; $display("FAIL nodecode_read got %o want 0", d); end
    iopage_addr = A_XCSR; #1;
    checks++; if (data_out !== 16'd0) begin errors++; $display("FAIL idle_bus got %o want 0", data_out); end
  endtask

  task automatic test_tx(input logic [7:0] b, input bit bop, input bit second);
    logic [15:0] d;
    logic [9:0]  frame;
    int bad;
    frame = {1'b1, b, 1'b0};
    bad = 0;
    bus_write(A_XBUF, {8'hFF, b}, bop);
    peek(A_XCSR, d);
    checks++; if (d !== 16'o000000) begin errors++; $display("FAIL tx_busy_xcsr got %o want 000000", d); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_edge_n got %b want 1", tx); end
    for (int c = 1; c <= 10 * D; c++) begin
      @(posedge clk); #1;
      iopage_wr = 1'b0;
      if (tx !== frame[(c - 1) / D]) bad++;
      if (second && c == 3 * D) begin
        iopage_addr = A_XBUF; data_in = {8'h00, ~b}; iopage_wr = 1'b1;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL tx_frame byte %h bad cycles %0d want 0", b, bad); end
    peek(A_XCSR, d);
    checks++; if (d !== 16'o000000) begin errors++; $display("FAIL tx_ready_early got %o want 000000", d); end
    @(posedge clk); #1;
    peek(A_XCSR, d);
    checks++; if (d !== 16'o000200) begin errors++; $display("FAIL tx_ready_end got %o want 000200", d); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_idle got %b want 1", tx); end
  endtask

  task automatic test_rx_basic();
    logic [15:0] d;
    send_frame(8'h55, 1);
    repeat (3) @(posedge clk); #1;
    model_rx(8'h55, 1);
    bus_read(A_RCSR, 0, d);
    checks++; if (d !== 16'o000200) begin errors++; $display("FAIL rx55_rcsr got %o want 000200", d); end
    bus_read(A_RBUF, 0, d);
    checks++; if (d !== 16'o000125) begin errors++; $display("FAIL rx55_rbuf got %o want 000125", d); end
    model_rd();
    bus_read(A_RCSR, 0, d);
    checks++; if (d !== 16'o000000) begin errors++; $display("FAIL rx55_clear got %o want 000000", d); end
  endtask

  task automatic test_overrun_fe();
    logic [15:0] d;
    send_frame(8'h41, 1);
    send_frame(8'h42, 1);
    repeat (3) @(posedge clk); #1;
    model_rx(8'h41, 1);
    model_rx(8'h42, 1);
    bus_read(A_RBUF, 0, d);
    checks++; if (d !== 16'o140102) begin errors++; $display("FAIL overrun got %o want 140102", d); end
    model_rd();
    send_frame(8'h33, 0);
    repeat (3) @(posedge clk); #1;
    model_rx(8'h33, 0);
    bus_read(A_RBUF, 0, d);
    checks++; if (d !== (16'o120000 | 16'h0033)) begin errors++; $display("FAIL framing got %o want %o", d, 16'o120000 | 16'h0033); end
    model_rd();
  endtask

  task automatic test_rx_random();
    logic [15:0] d;
    logic [15:0] e;
    logic [7:0]  b;
    bit          stop;
    int          act;
    for (int n = 0; n < 12; n++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop);
      repeat ($urandom_range(2, 5)) @(posedge clk);
      #1;
      model_rx(b, stop);
      bus_read(A_RCSR, 0, d);
      checks++; if (d !== exp_rcsr()) begin errors++; $display("FAIL rnd_rcsr n=%0d got %o want %o", n, d, exp_rcsr()); end
      act = $urandom_range(0, 2);
      e = exp_rbuf();
      if (act == 0) begin
        bus_read(A_RBUF, 0, d);
        checks++; if (d !== e) begin errors++; $display("FAIL rnd_rbuf_word n=%0d got %o want %o", n, d, e); end
        model_rd();
      end else if (act == 1) begin
        bus_read(A_RBUF, 1, d);
        checks++; if (d !== {8'h00, e[7:0]}) begin errors++; $display("FAIL rnd_rbuf_lo n=%0d got %o want %o", n, d, {8'h00, e[7:0]}); end
        model_rd();
      end else begin
        bus_read(A_RBUF | 13'd1, 1, d);
        checks++; if (d !== {8'h00, e[15:8]}) begin errors++; $display("FAIL rnd_rbuf_hi n=%0d got %o want %o", n, d, {8'h00, e[15:8]}); end
      end
    end
    bus_read(A_RBUF, 0, d);
    model_rd();
  endtask

  task automatic test_collision();
    logic [15:0] d;
    logic [7:0]  b;
    int k;
    k = -1;
    b = 8'($urandom);
    @(posedge clk); #1;
    fork
      send_frame(8'h3C, 1);
      begin
        iopage_addr = A_RCSR; iopage_rd = 1'b1;
        for (int c = 1; c <= 12 * D && k < 0; c++) begin
          @(posedge clk); #1;
          if (data_out[7]) k = c;
        end
        iopage_rd = 1'b0;
      end
    join
    repeat (3) @(posedge clk); #1;
    model_rx(8'h3C, 1);
    checks++;
    if (k < 9 * D + D / 2 || k > 9 * D + D / 2 + 4) begin
      errors++; $display("FAIL rx_latency got %0d want %0d..%0d", k, 9 * D + D / 2, 9 * D + D / 2 + 4);
    end else begin
      fork
        send_frame(b, 1);
        begin
          repeat (k - 1) @(posedge clk);
          @(negedge clk);
          iopage_addr = A_RBUF; iopage_rd = 1'b1;
          #1 d = data_out;
          @(posedge clk); #1;
          iopage_rd = 1'b0;
        end
      join
      checks++; if (d !== exp_rbuf()) begin errors++; $display("FAIL coll_preclear got %o want %o", d, exp_rbuf()); end
      repeat (3) @(posedge clk); #1;
      m_done = 1; m_ovr = 1; m_fe = 0; m_data = b;
      bus_read(A_RCSR, 0, d);
      checks++; if (d !== exp_rcsr()) begin errors++; $display("FAIL coll_rcsr got %o want %o", d, exp_rcsr()); end
      bus_read(A_RBUF, 0, d);
      checks++; if (d !== exp_rbuf()) begin errors++; $display("FAIL coll_rbuf got %o want %o", d, exp_rbuf()); end
      model_rd();
    end
  endtask

  task automatic test_interrupts();
    logic [15:0] d;
    send_frame(8'hA5, 1);
    repeat (3) @(posedge clk); #1;
    model_rx(8'hA5, 1);
    checks++; if (rx_int !== 1'b0) begin errors++; $display("FAIL rxint_masked got %b want 0", rx_int); end
    bus_write(A_RCSR, 16'o000100, 0);
    m_rie = 1;
    checks++; if (rx_int !== 1'b1) begin errors++; $display("FAIL rxint_set got %b want 1", rx_int); end
    bus_write(A_RCSR | 13'd1, 16'hFFFF, 1);
    bus_read(A_RCSR, 0, d);
    checks++; if (d !== exp_rcsr()) begin errors++; $display("FAIL odd_byte_wr got %o want %o", d, exp_rcsr()); end
    bus_read(A_RBUF, 0, d);
    model_rd();
    checks++; if (rx_int !== 1'b0) begin errors++; $display("FAIL rxint_clear got %b want 0", rx_int); end
    bus_write(A_RCSR, 16'o000000, 0);
    m_rie = 0;
    bus_write(A_XCSR, 16'o000100, 0);
    checks++; if (tx_int !== 1'b1) begin errors++; $display("FAIL txint_set got %b want 1", tx_int); end
    bus_read(A_XCSR, 0, d);
    checks++; if (d !== 16'o000300) begin errors++; $display("FAIL xcsr_ie got %o want 000300", d); end
    bus_write(A_XBUF, 16'h005A, 0);
    checks++; if (tx_int !== 1'b0) begin errors++; $display("FAIL txint_busy got %b want 0", tx_int); end
    repeat (10 * D + 2) @(posedge clk);
    #1;
    checks++; if (tx_int !== 1'b1) begin errors++; $display("FAIL txint_done got %b want 1", tx_int); end
    bus_write(A_XCSR, 16'o000000, 0);
  endtask

  task automatic test_maint();
    logic [15:0] d;
`ifdef KL11_LOOPBACK_EN
    int bad;
    bad = 0;
    bus_write(A_XCSR, 16'o000004, 0);
    bus_read(A_XCSR, 0, d);
    checks++; if (d !== 16'o000204) begin errors++; $display("FAIL maint_rw got %o want 000204", d); end
    bus_read(A_RBUF, 0, d);
    model_rd();
    bus_write(A_XBUF, 16'h007A, 0);
    for (int c = 1; c <= 10 * D + 1; c++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL maint_tx_pin bad cycles %0d want 0", bad); end
    model_rx(8'h7A, 1);
    peek(A_RCSR, d);
    checks++; if (d !== exp_rcsr()) begin errors++; $display("FAIL loop_rcsr got %o want %o", d, exp_rcsr()); end
    bus_read(A_RBUF, 0, d);
    checks++; if (d !== 16'o000172) begin errors++; $display("FAIL loop_rbuf got %o want 000172", d); end
    model_rd();
    bus_write(A_XCSR, 16'o000000, 0);
`else
    bus_write(A_XCSR, 16'o000004, 0);
    bus_read(A_XCSR, 0, d);
    checks++; if (d !== 16'o000200) begin errors++; $display("FAIL maint_ro got %o want 000200", d); end
`endif
  endtask

  task automatic test_reset_midframe();
    logic [15:0] d;
    bus_write(A_XBUF, 16'h0000, 0);
    repeat (3 * D) @(posedge clk);
    #2;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midframe_tx got %b want 0", tx); end
    reset_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL async_reset_tx got %b want 1", tx); end
    peek(A_XCSR, d);
    checks++; if (d !== 16'o000200) begin errors++; $display("FAIL async_reset_xcsr got %o want 000200", d); end
    @(negedge clk); reset_n = 1'b1;
    model_reset();
    repeat (10 * D + 2) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL post_reset_tx got %b want 1", tx); end
    bus_read(A_RBUF, 0, d);
    checks++; if (d !== exp_rbuf()) begin errors++; $display("FAIL post_reset_rbuf got %o want %o", d, exp_rbuf()); end
  endtask

  initial begin
    test_reset();
    test_tx(8'h48, 0, 1);
    test_tx(8'($urandom), 1, 0);
    test_tx(8'($urandom), 0, 1);
    test_rx_basic();
    test_overrun_fe();
    test_rx_random();
    test_collision();
    test_interrupts();
    test_maint();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
